// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline stage register with 2-entry skid buffer, flush and stall counter
// Main register drives dn_*; the skid register absorbs one entry so up_ready can stay registered.
module pipe_stage_buf #(
  parameter int                 CTRL_W      = 9,
  parameter int                 DATA_W      = 96,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = {DATA_W{1'b0}},
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                up_ready_q, up_ready_d;
  logic                dn_valid_q, dn_valid_d;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic up_fire, dn_fire;
  logic load_main_up, load_main_skid, load_skid_up;

  assign up_fire = up_valid & up_ready_q;
  assign dn_fire = dn_valid_q & dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (up_fire) state_d = ONE;
        ONE: begin
          if (dn_fire && !up_fire)      state_d = EMPTY;
          else if (up_fire && !dn_fire) state_d = FULL;
        end
        FULL: if (dn_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath load strobes; flush overrides them in the register block.
  always_comb begin
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_up   = 1'b0;
    case (state_q)
      EMPTY: load_main_up = up_fire;
      ONE: begin
        load_main_up = up_fire & dn_fire;
        load_skid_up = up_fire & ~dn_fire;
      end
      FULL: load_main_skid = dn_fire;
      default: ;
    endcase
    up_ready_d = ~flush & (state_d != FULL);
    dn_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_ready_q  <= 1'b0;
      dn_valid_q  <= 1'b0;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= BUBBLE_DATA;
      skid_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= BUBBLE_DATA;
    end else begin
      up_ready_q <= up_ready_d;
      dn_valid_q <= dn_valid_d;
      if (flush) begin
        main_ctrl_q <= BUBBLE_CTRL;
        main_data_q <= BUBBLE_DATA;
        skid_ctrl_q <= BUBBLE_CTRL;
        skid_data_q <= BUBBLE_DATA;
      end else begin
        if (load_main_up) begin
          main_ctrl_q <= up_ctrl;
          main_data_q <= up_data;
        end else if (load_main_skid) begin
          main_ctrl_q <= skid_ctrl_q;
          main_data_q <= skid_data_q;
        end
        if (load_skid_up) begin
          skid_ctrl_q <= up_ctrl;
          skid_data_q <= up_data;
        end
      end
    end
  end

  // Saturating stall counter; clear beats a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (dn_valid_q && !dn_ready && !flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign up_ready  = up_ready_q;
  assign dn_valid  = dn_valid_q;
  assign dn_ctrl   = dn_valid_q ? main_ctrl_q : BUBBLE_CTRL;
  assign dn_data   = main_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf against a queue-based model
module tb_pipe_stage_buf;

  localparam int CW = 9;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam logic [DW-1:0] BD = 16'hA5A5;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_valid, up_ready, dn_valid, dn_ready, flush, clr_stats;
  logic [CW-1:0] up_ctrl, dn_ctrl;
  logic [DW-1:0] up_data, dn_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  pipe_stage_buf #(
    .CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(9'h000), .BUBBLE_DATA(BD), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_ctrl(up_ctrl), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_ctrl(dn_ctrl), .dn_data(dn_data),
    .flush(flush), .clr_stats(clr_stats), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  // Reference: an ordered queue of held entries plus the readiness/stat rules.
  ent_t          mq[$];
  logic          m_ready;
  logic [DW-1:0] m_main;
  int            m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_main  = BD;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    logic uf, df;
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    uf = up_valid && m_ready;
    df = (mq.size() > 0) && dn_ready;
    if (clr_stats) m_cnt = 0;
    else if (mq.size() > 0 && !dn_ready && !flush && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      mq.delete();
      m_main  = BD;
      m_ready = 1'b0;
    end else begin
      if (df) void'(mq.pop_front());
      if (uf) begin
        e.c = up_ctrl;
        e.d = up_data;
        mq.push_back(e);
      end
      if (mq.size() > 0) m_main = mq[0].d;
      m_ready = (mq.size() < 2);
    end
  endtask

  task automatic compare_model();
    chk("m_dn_valid", dn_valid, mq.size() != 0);
    chk("m_occupancy", occupancy, mq.size());
    chk("m_up_ready", up_ready, m_ready);
    chk("m_dn_ctrl", dn_ctrl, (mq.size() != 0) ? mq[0].c : 9'h000);
    chk("m_dn_data", dn_data, m_main);
    chk("m_stall_cnt", stall_cnt, m_cnt);
  endtask

  // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
  task automatic step(input logic uv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic dr, input logic fl, input logic cl);
    up_valid  = uv;
    up_ctrl   = c;
    up_data   = d;
    dn_ready  = dr;
    flush     = fl;
    clr_stats = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic          uv;
    logic          dr;
    logic [DW-1:0] d;
    logic          ev;
    logic [1:0]    eocc;
    logic          er;
    logic [CW-1:0] ectrl;
    logic [DW-1:0] edata;
    logic [NW-1:0] ecnt;
  } vec_t;

  vec_t bp[7];

  initial begin
    bp[0] = '{1, 0, 16'd1, 1, 2'd1, 1, 9'h0F1, 16'd1, 4'd0};
    bp[1] = '{1, 0, 16'd2, 1, 2'd2, 0, 9'h0F1, 16'd1, 4'd1};
    bp[2] = '{1, 0, 16'd3, 1, 2'd2, 0, 9'h0F1, 16'd1, 4'd2};
    bp[3] = '{1, 0, 16'd3, 1, 2'd2, 0, 9'h0F1, 16'd1, 4'd3};
    bp[4] = '{1, 1, 16'd3, 1, 2'd1, 1, 9'h0F2, 16'd2, 4'd3};
    bp[5] = '{1, 1, 16'd3, 1, 2'd1, 1, 9'h0F3, 16'd3, 4'd3};
    bp[6] = '{0, 1, 16'd3, 0, 2'd0, 1, 9'h000, 16'd3, 4'd3};

    rst_n = 1'b0; up_valid = 1'b1; up_ctrl = 9'h1FF; up_data = 16'h1234;
    dn_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    model_reset();
    @(negedge clk);

    // reset with a valid upstream request held
    for (int i = 0; i < 3; i++) begin
      step(1, 9'h1FF, 16'h1234, 0, 0, 0);
      chk("rst_dn_valid", dn_valid, 0);
      chk("rst_dn_ctrl", dn_ctrl, 9'h000);
      chk("rst_dn_data", dn_data, BD);
      chk("rst_up_ready", up_ready, 0);
    end
    rst_n = 1'b1;
    step(1, 9'h1FF, 16'h1234, 0, 0, 0);
    chk("rel_up_ready", up_ready, 1);
    chk("rel_no_accept", occupancy, 0);

    // streaming 1..8
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1, 9'h0F0 | 9'(i), 16'(i), 1, 0, 0);
      chk("stream_data", dn_data, i);
      chk("stream_valid", dn_valid, 1);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("stream_drain", dn_valid, 0);
    chk("stream_stall", stall_cnt, 0);

    // backpressure table
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(bp[i].uv, 9'h0F0 | bp[i].d[CW-1:0], bp[i].d, bp[i].dr, 0, 0);
      chk("bp_valid", dn_valid, bp[i].ev);
      chk("bp_occ", occupancy, bp[i].eocc);
      chk("bp_ready", up_ready, bp[i].er);
      chk("bp_ctrl", dn_ctrl, bp[i].ectrl);
      chk("bp_data", dn_data, bp[i].edata);
      chk("bp_cnt", stall_cnt, bp[i].ecnt);
    end

    // flush while FULL, C offered on the flush cycle and the one after
    do_reset();
    step(1, 9'h0AA, 16'hAAAA, 0, 0, 0);
    step(1, 9'h0BB, 16'hBBBB, 0, 0, 0);
    chk("fl_full", occupancy, 2);
    step(1, 9'h0CC, 16'hCCCC, 0, 1, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", dn_valid, 0);
    chk("fl_ctrl", dn_ctrl, 9'h000);
    chk("fl_data", dn_data, BD);
    chk("fl_ready0", up_ready, 0);
    chk("fl_cnt_kept", stall_cnt, 1);
    step(1, 9'h0CC, 16'hCCCC, 0, 0, 0);
    chk("fl_ready1", up_ready, 1);
    chk("fl_c_dropped", occupancy, 0);
    step(1, 9'h0DD, 16'hDDDD, 1, 0, 0);
    chk("fl_next", dn_data, 16'hDDDD);

    // saturation and clear
    do_reset();
    step(1, 9'h011, 16'h0011, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
    chk("sat_cnt", stall_cnt, 15);
    step(0, 0, 0, 0, 0, 1);
    chk("clr_cnt", stall_cnt, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("clr_then_one", stall_cnt, 1);

    // async reset pulse between edges while FULL
    do_reset();
    step(1, 9'h021, 16'h0021, 0, 0, 0);
    step(1, 9'h022, 16'h0022, 0, 0, 0);
    chk("ar_full", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", dn_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_ready", up_ready, 0);
    chk("ar_ctrl", dn_ctrl, 9'h000);
    chk("ar_data", dn_data, BD);
    chk("ar_cnt", stall_cnt, 0);
    model_reset();
    #1 rst_n = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    chk("ar_rise", up_ready, 1);
    step(1, 9'h033, 16'h0033, 1, 0, 0);
    chk("ar_fresh", dn_data, 16'h0033);
    step(0, 0, 0, 1, 0, 0);
    chk("ar_no_stale", dn_valid, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(1, 0)), 9'($urandom), 16'($urandom),
           ($urandom_range(99, 0) < 60), ($urandom_range(99, 0) < 3),
           ($urandom_range(99, 0) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register: the generalised successor to the fixed inter-stage flip-flop banks between decode, execute, memory and writeback. It carries a control bundle and a data bundle, with the stage boundary handled by a valid/ready handshake. A 2-entry skid buffer keeps `up_ready` registered. The block also supports flush with bubble insertion and a per-stage stall counter.

## Interface
Parameters:
- `CTRL_W`, default 9: control bundle width (RegDst, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, halt, spare).
- `DATA_W`, default 96: data bundle width (register indices, operand values, imm, pc_inc, instr).
- `BUBBLE_CTRL`, default 0: control value emitted for a bubble. It must deassert all write/branch/halt bits.
- `BUBBLE_DATA`, default {DATA_W{1'b0}}: data value loaded at reset and at flush (e.g. a NOP opcode field).
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `up_valid`, in, 1: upstream holds a valid entry.
- `up_ready`, out, 1: the block accepts an entry this cycle (registered).
- `up_ctrl`, in, CTRL_W: upstream control bundle.
- `up_data`, in, DATA_W: upstream data bundle.
- `dn_valid`, out, 1: the output entry is valid.
- `dn_ready`, in, 1: downstream consumes the entry.
- `dn_ctrl`, out, CTRL_W: output control. Equals BUBBLE_CTRL whenever `dn_valid`=0.
- `dn_data`, out, DATA_W: output data.
- `flush`, in, 1: discard all held entries.
- `clr_stats`, in, 1: clear the stall counter.
- `occupancy`, out, 2: number of held entries (0..2).
- `stall_cnt`, out, CNT_W: saturating count of stalled cycles.

## Operation
- Storage consists of a main register (drives `dn_*`) and a skid register. Each holds ctrl and data.
- Handshake rules:
  - up-fire = `up_valid & up_ready`.
  - dn-fire = `dn_valid & dn_ready`.
  - `up_ready` = (occupancy < 2) and no flush in the previous cycle. It is registered, with no combinational path from `dn_ready` to `up_ready`.
- States are EMPTY (0), ONE (1) and FULL (2). `occupancy` equals the state.
- EMPTY:
  - up-fire: main ← up, go to ONE.
  - otherwise stay in EMPTY.
- ONE:
  - up-fire and dn-fire: main ← up, stay in ONE.
  - dn-fire only: go to EMPTY.
  - up-fire only: skid ← up, go to FULL.
  - neither: hold.
- FULL:
  - `up_ready`=0.
  - dn-fire: main ← skid, go to ONE.
  - otherwise hold.
- Entries leave in arrival order. No entry is duplicated or dropped except by flush.
- `flush` has the highest priority:
  - Next state is EMPTY.
  - Main and skid ctrl are loaded with BUBBLE_CTRL; main and skid data with BUBBLE_DATA.
  - Any same-cycle up-fire is discarded.
  - `up_ready` is 0 in the cycle after flush and 1 in the following cycle.
- `dn_ctrl` is gated: `dn_valid` ? main_ctrl : BUBBLE_CTRL. `dn_data` is not gated.
- `stall_cnt`:
  - Increments each cycle with `dn_valid & ~dn_ready & ~flush`.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - `clr_stats` sets it to 0 and wins over a same-cycle increment.
  - `flush` does not clear it.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate):
  - state EMPTY
  - `dn_valid`=0, `up_ready`=0, `occupancy`=0, `stall_cnt`=0
  - `dn_ctrl`=BUBBLE_CTRL, `dn_data`=BUBBLE_DATA
- Reset release:
  - `up_ready` rises on the first rising edge after `rst_n` deasserts.
  - A reset asserted mid-transfer drops all entries with no partial update.
- Latency: 1 cycle. An entry accepted at edge N is on `dn_*` with `dn_valid`=1 after edge N.
- Throughput: 1 entry/cycle while `dn_ready`=1.
- `up_ready` drops the cycle after the block becomes FULL and rises the cycle after the first dn-fire from FULL.
- All outputs except `dn_ctrl` are registered. `dn_ctrl` adds only a mux after the registers.

## Test plan
- Reset and default bubble: hold `rst_n`=0 for 3 cycles with up_valid=1 and up_ctrl=9'h1FF. Required: `dn_valid`=0, `dn_ctrl`=0, `dn_data`=BUBBLE_DATA, `up_ready`=0. After release, `up_ready`=1 after 1 edge.
- Streaming: send entries data=1..8 back-to-back with `dn_ready`=1. Required: outputs 1..8 in order, one per cycle, first output 1 cycle after acceptance, `stall_cnt`=0.
- Backpressure and skid:
  - Set `dn_ready`=0 while sending 1,2,3 with up_valid held.
  - Required: occupancy goes 1→2, `up_ready`=0 after entry 2, and 3 is not accepted.
  - Raise `dn_ready`. Required: output 1,2,3 in order with no loss.
  - Required: `stall_cnt` equals the number of stalled cycles.
- Flush mid-stall:
  - In FULL with entries A,B, assert `flush` with up_valid=1 and data C.
  - Required: next cycle `occupancy`=0, `dn_valid`=0, `dn_ctrl`=BUBBLE_CTRL, C discarded, `up_ready`=0 for 1 cycle then 1.
- Counter saturation and clear:
  - With CNT_W=4, stall 20 cycles. Required: `stall_cnt`=15.
  - Assert `clr_stats` while still stalled. Required: `stall_cnt`=0, then 1 on the next stalled cycle.
- Async reset mid-operation: pulse `rst_n` low between edges while FULL. Required: outputs go to reset values immediately without waiting for a `clk` edge, and no stale entry appears afterwards.
